// File: rtl/sync_load_updown_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_load_updown_counter_if
//  Description : Bus bundle for sync_load_updown_counter.
//                Carries the load/direction controls and the load data
//                towards the counter, and the count/zero/wrap status back.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals (WIDTH = counter width in bits)
//    load    1      synchronous parallel-load request, active-high
//    updown  1      direction: 1 = count up, 0 = count down
//    d_in    WIDTH  value loaded when load = 1
//    count   WIDTH  current counter value (registered)
//    zero    1      high when count == 0
//    wrap    1      one-cycle pulse after a wrapping (or saturated) step
//  Modports
//    master  drives controls, observes status (the counter's user)
//    slave   observes controls, drives status (the counter itself)
// ============================================================================
interface sync_load_updown_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             load;
  logic             updown;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             wrap;

  modport master (
    output load,
    output updown,
    output d_in,
    input  count,
    input  zero,
    input  wrap
  );

  modport slave (
    input  load,
    input  updown,
    input  d_in,
    output count,
    output zero,
    output wrap
  );

endinterface : sync_load_updown_counter_if
`default_nettype wire

// File: rtl/sync_load_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_load_updown_counter
//  Description : Loadable, free-running binary up/down counter.
//                Steps once per rising clock edge in the direction given by
//                updown, or takes d_in when load is high (load wins).
//                zero decodes the count register; wrap is a registered
//                one-cycle pulse following a step that crossed the
//                all-ones / zero boundary.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      counter and load-data width, legal range 2..32 (default 4)
//    RESET_VAL  value of count during reset, truncated to WIDTH (default 0)
//  Build option
//    SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN
//      undefined : modular wrap-around, wrap flags the wrap event
//      defined   : the counter saturates at all-ones / zero and wrap flags
//                  a step that was blocked by saturation
//  Ports
//    clk   in   rising-edge clock
//    rst   in   asynchronous active-low reset (rst = 0 resets)
//    bus   slave modport of sync_load_updown_counter_if:
//            load, updown, d_in in; count, zero, wrap out
// ============================================================================
module sync_load_updown_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  sync_load_updown_counter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] c_reset_val = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_all_ones  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_all_zero  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_one       = {{(WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_at_limit;

  // Boundary detection. Only the boundary lying in the current direction
  // matters: counting up from zero or down from all-ones is an ordinary step.
  assign w_at_max   = (r_count == c_all_ones);
  assign w_at_min   = (r_count == c_all_zero);
  assign w_at_limit = bus.updown ? w_at_max : w_at_min;

  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;

`ifdef SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN
    // Saturating build: a step that would cross the boundary is suppressed
    // and the suppression is reported on wrap in the following cycle.
    if (w_at_limit) begin
      w_count_next = r_count;
    end else if (bus.updown) begin
      w_count_next = r_count + c_one;
    end else begin
      w_count_next = r_count - c_one;
    end
    w_wrap_next = w_at_limit;
`else
    // Modular build: the adder naturally rolls over modulo 2^WIDTH; the
    // boundary flag computed from the pre-step value marks the rollover.
    if (bus.updown) begin
      w_count_next = r_count + c_one;
    end else begin
      w_count_next = r_count - c_one;
    end
    w_wrap_next = w_at_limit;
`endif

    // Load has priority over counting and always clears wrap, even when the
    // loaded value equals the current count.
    if (bus.load) begin
      w_count_next = bus.d_in;
      w_wrap_next  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers. Reset assertion is asynchronous; release takes effect on the
  // first rising edge that sees rst high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= c_reset_val;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. zero decodes the register only, so it never glitches on inputs.
  // --------------------------------------------------------------------------
  assign bus.count = r_count;
  assign bus.zero  = w_at_min;
  assign bus.wrap  = r_wrap;

endmodule : sync_load_updown_counter
`default_nettype wire

// File: tb/tb_sync_load_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_load_updown_counter
//  Description : Directed self-checking bench for sync_load_updown_counter
//                (WIDTH = 4, RESET_VAL = 0). Expected values are written out
//                by hand; the saturating build selects its own expectations
//                via SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_load_updown_counter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sync_load_updown_counter_if #(.WIDTH(WIDTH)) bus_if ();

  sync_load_updown_counter #(
    .WIDTH     (WIDTH),
    .RESET_VAL (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_count,
                           input logic e_zero, input logic e_wrap);
    check_val({tag, ".count"}, {28'd0, bus_if.count}, {28'd0, e_count});
    check_val({tag, ".zero"},  {31'd0, bus_if.zero},  {31'd0, e_zero});
    check_val({tag, ".wrap"},  {31'd0, bus_if.wrap},  {31'd0, e_wrap});
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus_if.load   = 1'b0;
    bus_if.updown = 1'b1;
    bus_if.d_in   = 4'd0;

    // Async reset asserted before any clock edge (first edge at t=5).
    #1 rst = 1'b0;
    #1 check_all("rst_async", 4'd0, 1'b1, 1'b0);

    // Held low across edges: state must not move.
    step();
    step();
    check_all("rst_hold", 4'd0, 1'b1, 1'b0);

    // Release and count up 1..6.
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_all($sformatf("up%0d", i), i[3:0], 1'b0, 1'b0);
    end

    // Load 10 (updown low, must be ignored), then up two steps.
    bus_if.load   = 1'b1;
    bus_if.d_in   = 4'b1010;
    bus_if.updown = 1'b0;
    step();
    check_all("load10", 4'd10, 1'b0, 1'b0);
    bus_if.load   = 1'b0;
    bus_if.updown = 1'b1;
    step();
    step();
    check_all("up12", 4'd12, 1'b0, 1'b0);

    // Down six steps 12 -> 6.
    bus_if.updown = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_val($sformatf("down%0d", i), {28'd0, bus_if.count}, 32'(12 - i));
    end

    // Load 3, down two steps -> 1.
    bus_if.load = 1'b1;
    bus_if.d_in = 4'b0011;
    step();
    check_all("load3", 4'd3, 1'b0, 1'b0);
    bus_if.load = 1'b0;
    step();
    step();
    check_all("down_to1", 4'd1, 1'b0, 1'b0);

    // Upper boundary: load 15, step up.
    bus_if.load   = 1'b1;
    bus_if.d_in   = 4'd15;
    bus_if.updown = 1'b1;
    step();
    check_all("load15", 4'd15, 1'b0, 1'b0);
    bus_if.load = 1'b0;
    step();
`ifdef SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN
    check_all("up_sat", 4'd15, 1'b0, 1'b1);
`else
    check_all("up_wrap", 4'd0, 1'b1, 1'b1);
`endif

    // Load 0 clears wrap; then step down across the lower boundary.
    bus_if.load   = 1'b1;
    bus_if.d_in   = 4'd0;
    bus_if.updown = 1'b0;
    step();
    check_all("load0", 4'd0, 1'b1, 1'b0);
    bus_if.load = 1'b0;
    step();
`ifdef SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN
    check_all("down_sat", 4'd0, 1'b1, 1'b1);
    bus_if.d_in = 4'd0;
`else
    check_all("down_wrap", 4'd15, 1'b0, 1'b1);
    bus_if.d_in = 4'd15;
`endif

    // Load of the current value: count unchanged, wrap cleared.
    bus_if.load = 1'b1;
    step();
`ifdef SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN
    check_all("load_same", 4'd0, 1'b1, 1'b0);
`else
    check_all("load_same", 4'd15, 1'b0, 1'b0);
`endif

    // Load priority while updown toggles.
    bus_if.d_in   = 4'd5;
    bus_if.updown = 1'b1;
    step();
    check_all("prio_up", 4'd5, 1'b0, 1'b0);
    bus_if.d_in   = 4'd9;
    bus_if.updown = 1'b0;
    step();
    check_all("prio_dn", 4'd9, 1'b0, 1'b0);

    // Reset asserted mid-cycle during a load: immediate clear.
    bus_if.d_in = 4'd7;
    #3 rst = 1'b0;
    #1 check_all("rst_mid", 4'd0, 1'b1, 1'b0);
    step();
    check_all("rst_ignore_load", 4'd0, 1'b1, 1'b0);

    // Release: the pending load lands on the first edge with rst high.
    rst = 1'b1;
    step();
    check_all("load_after_rst", 4'd7, 1'b0, 1'b0);
    bus_if.load = 1'b0;
    step();
    check_all("down6", 4'd6, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_sync_load_updown_counter
`default_nettype wire

// File: doc/sync_load_updown_counter.md
Name: sync_load_updown_counter

Overview:
- Synchronous, loadable, free-running binary up/down counter of parameterisable width.
- Counts one step per rising clock edge in the direction selected by `updown`.
- Can be parallel-loaded from `d_in`; flags zero and wrap events.
- General-purpose timing/sequencing primitive for control datapaths.

Parameters:
- WIDTH, 4, counter and load-data width in bits (legal range 2..32).
- RESET_VAL, 0, value `count` takes during reset (truncated to WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- load  input  1  synchronous parallel-load request, active-high.
- updown  input  1  direction: 1 = count up, 0 = count down.
- d_in  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current counter value (registered).
- zero  output  1  high when count == 0 (combinational decode of the register).
- wrap  output  1  registered one-cycle pulse; high in the cycle after a count step wrapped (up from all-ones, or down from 0).

Behaviour:
- One clock domain: clk. All state updates occur on the rising edge of clk.
- Reset:
  - rst=0 asynchronously forces count=RESET_VAL and wrap=0, independent of clk.
  - State holds while rst=0.
  - Release is synchronous to clk; the first update occurs on the first rising edge with rst=1.
- Priority per rising edge, with rst=1: load > count.
- load=1:
  - count <= d_in; wrap <= 0.
  - updown is ignored that cycle.
  - Load latency: d_in visible on count one cycle after the sampling edge.
- load=0, updown=1: count <= count + 1, modulo 2^WIDTH.
- load=0, updown=0: count <= count - 1, modulo 2^WIDTH.
- No hold/enable input; the counter advances every cycle when not loading or in reset.
- Wrap rules:
  - Up from 2^WIDTH-1 gives 0, with wrap=1 for the next cycle.
  - Down from 0 gives 2^WIDTH-1, with wrap=1 for the next cycle.
  - Otherwise wrap=0.
- Direction change takes effect on the next edge; there is no pipeline delay and no glitch step.
- A load of a value equal to the current count is still a load: count unchanged, wrap=0.
- Reset asserted mid-count or mid-load overrides everything immediately.
- zero reflects count combinationally from the register; it never depends on inputs directly.
- All outputs are defined (no X) after the first reset assertion.

Optional Feature:
- Macro: SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping: up at 2^WIDTH-1 holds at 2^WIDTH-1; down at 0 holds at 0.
  - wrap pulses 1 in the cycle after a step was blocked by saturation (acts as a saturation flag).
  - Load behaviour unchanged.
- Undefined: modular wrap-around as specified above.

Test Plan:
- Reset: rst=0 for 10 time units mid-cycle → count=0, zero=1, wrap=0 immediately (before next edge); hold low across edges → stays 0.
- Count up: after reset release with updown=1, load=0, run 6 edges → count goes 1..6, zero=0, wrap=0.
- Load then up: d_in=4'b1010 with load=1 for one edge → count=10 next cycle; 2 more edges → 12.
- Down count and load: updown=0 for 6 edges from 12 → 6; then load 4'b0011 → 3; 2 edges down → 1.
- Wrap boundaries:
  - Load 15, updown=1, one edge → count=0, wrap=1 for one cycle, zero=1.
  - Load 0, updown=0, one edge → count=15, wrap=1.
  - With SYNC_LOAD_UPDOWN_COUNTER_SATURATE_EN: count stays 15 / 0 and wrap=1.
- Priority: load=1 and updown toggling on same edge → count=d_in. Assert rst=0 during load=1 → count=0 asynchronously; load ignored until release.
